// File: rtl/popcount_pkg.sv
// Shared defaults and width helper for the popcount accumulator.
package popcount_pkg;

    localparam int DEFAULT_IN_W  = 8;
    localparam int DEFAULT_ACC_W = 16;

    // Bits needed to hold a count of 0..in_w without truncation.
    function automatic int count_width(input int in_w);
        return $clog2(in_w + 1);
    endfunction

endpackage

// File: rtl/popcount_comb.sv
// Combinational ones-counter: number of set bits in data.
module popcount_comb
    import popcount_pkg::*;
#(
    parameter int IN_W = DEFAULT_IN_W,
    localparam int CW  = count_width(IN_W)
) (
    input  logic [IN_W-1:0] data,
    output logic [CW-1:0]   count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < IN_W; i++) begin
            count = count + CW'(data[i]);
        end
    end

endmodule

// File: rtl/popcount_acc.sv
// Two-stage popcount pipeline with a saturating running sum of emitted counts.
module popcount_acc
    import popcount_pkg::*;
#(
    parameter int IN_W  = DEFAULT_IN_W,
    parameter int ACC_W = DEFAULT_ACC_W,
    localparam int CW   = count_width(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in,
    input  logic             clr,
    output logic             out_valid,
    output logic [CW-1:0]    out,
    output logic [ACC_W-1:0] acc,
    output logic             sat
);

    localparam logic [ACC_W:0] ACC_MAX = {1'b0, {ACC_W{1'b1}}};

    logic             s1_valid_reg;
    logic [IN_W-1:0]  s1_data_reg;
    logic [CW-1:0]    s1_count;
    logic             out_valid_reg;
    logic [CW-1:0]    out_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             sat_reg;

    logic [ACC_W-1:0] acc_base;
    logic             sat_base;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_next;
    logic             sat_next;

    popcount_comb #(.IN_W(IN_W)) u_count (
        .data  (s1_data_reg),
        .count (s1_count)
    );

    // clr wipes the old total first, so a same-edge emission lands on zero.
    always_comb begin
        acc_base = clr ? '0 : acc_reg;
        sat_base = clr ? 1'b0 : sat_reg;
        acc_sum  = {1'b0, acc_base} + {{(ACC_W + 1 - CW){1'b0}}, s1_count};
        acc_next = acc_base;
        sat_next = sat_base;
        if (s1_valid_reg) begin
            if (acc_sum >= ACC_MAX) begin
                acc_next = '1;
                sat_next = 1'b1;
            end else begin
                acc_next = acc_sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_data_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            acc_reg       <= '0;
            sat_reg       <= 1'b0;
        end else begin
            s1_valid_reg  <= in_valid;
            s1_data_reg   <= in;
            out_valid_reg <= s1_valid_reg;
            // Bubbles leave the last count visible.
            if (s1_valid_reg) begin
                out_reg <= s1_count;
            end
            acc_reg <= acc_next;
            sat_reg <= sat_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign acc       = acc_reg;
    assign sat       = sat_reg;

endmodule

// File: tb/tb_popcount_acc.sv
// Scoreboard bench for popcount_acc: random and directed stimulus vs. a queue-based reference.
module tb_popcount_acc;
    import popcount_pkg::*;

    localparam int IN_W    = 8;
    localparam int ACC_W   = 10;
    localparam int CW      = count_width(IN_W);
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             clr;
    logic             out_valid;
    logic [CW-1:0]    out;
    logic [ACC_W-1:0] acc;
    logic             sat;

    popcount_acc #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in        (in_data),
        .clr       (clr),
        .out_valid (out_valid),
        .out       (out),
        .acc       (acc),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int cnt;
    } exp_t;

    exp_t sbq[$];
    bit   clr_map[int];
    int   cyc = 0;
    int   model_acc = 0;
    int   model_sat = 0;
    int   last_out = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and record what the block must do with it.
    task automatic drive(input bit v, input logic [IN_W-1:0] d, input bit c);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = d;
        clr      = c;
        clr_map[cyc + 1] = c;
        if (v) sbq.push_back('{cyc + 2, $countones(d)});
        $display("drive cyc=%0d valid=%0b in=%02h clr=%0b", cyc, v, d, c);
    endtask

    // Monitor: compares outputs against the reference after every edge.
    initial begin
        bit   emit;
        bit   clr_now;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_acc", 32'(acc), 32'd0);
                check("rst_sat", 32'(sat), 32'd0);
                continue;
            end
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                e = sbq.pop_front();
                check("missed_sample", 32'(e.due), 32'(cyc));
            end
            emit    = (sbq.size() > 0 && sbq[0].due == cyc);
            clr_now = clr_map.exists(cyc) ? clr_map[cyc] : 1'b0;
            check("out_valid", 32'(out_valid), 32'(emit));
            if (clr_now) begin
                model_acc = 0;
                model_sat = 0;
            end
            if (emit) begin
                e = sbq.pop_front();
                check("out_count", 32'(out), 32'(e.cnt));
                last_out = e.cnt;
                if (model_acc + e.cnt >= ACC_MAX) begin
                    model_acc = ACC_MAX;
                    model_sat = 1;
                end else begin
                    model_acc = model_acc + e.cnt;
                end
            end else begin
                check("out_held", 32'(out), 32'(last_out));
            end
            check("acc", 32'(acc), 32'(model_acc));
            check("sat", 32'(sat), 32'(model_sat));
            $display("mon cyc=%0d out_valid=%0b out=%0d acc=%0d sat=%0b", cyc, out_valid, out, acc, sat);
        end
    end

    initial begin
        logic [IN_W-1:0] v8;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        clr      = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_out", 32'(out), 32'd0);
        check("init_acc", 32'(acc), 32'd0);
        check("init_sat", 32'(sat), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Every 3-bit pattern back to back.
        for (int i = 0; i < 8; i++) drive(1'b1, IN_W'(i), 1'b0);
        // Valid/bubble/valid pattern.
        drive(1'b1, 8'h0F, 1'b0);
        drive(1'b0, 8'hFF, 1'b0);
        drive(1'b1, 8'h03, 1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        // clr landing on the same edge as an emission, then clr alone.
        drive(1'b1, 8'h1F, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            v8 = IN_W'($urandom);
            drive($urandom_range(3) != 0, v8, $urandom_range(31) == 0);
        end
        // Overflow into saturation, then keep adding.
        for (int i = 0; i < 140; i++) drive(1'b1, 8'hFF, 1'b0);
        // Land exactly on the maximum from zero: 127*8 + 7.
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 127; i++) drive(1'b1, 8'hFF, 1'b0);
        drive(1'b1, 8'h7F, 1'b0);
        drive(1'b1, 8'h01, 1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b0);

        // Asynchronous reset with samples in both stages.
        drive(1'b1, 8'hAA, 1'b0);
        drive(1'b1, 8'h77, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_out", 32'(out), 32'd0);
        check("async_acc", 32'(acc), 32'd0);
        check("async_sat", 32'(sat), 32'd0);
        sbq.delete();
        model_acc = 0;
        model_sat = 0;
        last_out  = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hC3;
        clr      = 1'b0;
        clr_map[cyc + 1] = 1'b0;
        sbq.push_back('{cyc + 2, 4});
        $display("drive cyc=%0d valid=1 in=c3 clr=0 (first after reset)", cyc);
        repeat (4) drive(1'b0, 8'h00, 1'b0);
        repeat (5) drive(1'b1, IN_W'($urandom), 1'b0);
        repeat (4) drive(1'b0, 8'h00, 1'b0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/popcount_acc.md
POPCOUNT_ACC -- requirements
Module: popcount_acc

Interface
REQ-001 The block SHALL have parameter IN_W, default 8, meaning the input sample width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter ACC_W, default 16, meaning the accumulator width in bits (legal range CW..32).
REQ-003 The block SHALL derive the constant CW = clog2(IN_W+1), meaning the per-sample count width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in carries a sample this cycle.
REQ-007 The block SHALL have port in, input, IN_W bits: the sample data.
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous clear of acc and sat.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out holds a fresh count this cycle.
REQ-010 The block SHALL have port out, output, CW bits: number of 1 bits in the sample.
REQ-011 The block SHALL have port acc, output, ACC_W bits: running sum of emitted counts.
REQ-012 The block SHALL have port sat, output, 1 bit: sticky flag set when acc has saturated.

Function
REQ-013 The block SHALL be a 2-stage pipeline: stage 1 registers in_valid and in; stage 2 registers the popcount of the stage-1 data and its valid bit.
REQ-014 For a sample accepted at edge N, out and out_valid=1 SHALL be present after edge N+2 (latency 2 cycles, throughput 1 sample per cycle, no back-pressure).
REQ-015 A cycle with in_valid=0 SHALL propagate a bubble: out_valid=0 two cycles later, with out holding its previous value.
REQ-016 out SHALL equal the exact count of ones in the sample, in the range 0..IN_W, with no truncation.
REQ-017 On each edge where stage 2 emits (the edge that sets out_valid=1), acc SHALL become min(acc + count, 2^ACC_W-1), evaluated at ACC_W+1 bits.
REQ-018 sat SHALL set on the edge where the unclipped sum exceeds 2^ACC_W-1, or where the sum equals it exactly; sat SHALL remain set until clr or reset.
REQ-019 When acc is already at maximum, further counts SHALL leave acc at maximum and sat=1.
REQ-020 With clr=1 and no emission on the same edge, the block SHALL load acc=0 and sat=0.
REQ-021 With clr=1 and an emission on the same edge, the block SHALL load acc=count, with sat set only if count alone reaches 2^ACC_W-1 (clear first, then add).
REQ-022 clr SHALL NOT flush the pipeline: samples in flight SHALL still emerge on out.

Reset
REQ-023 When rst_n=0, all registers SHALL clear immediately without waiting for clk: stage valids=0, out=0, out_valid=0, acc=0, sat=0.
REQ-024 Samples in flight when reset is asserted mid-stream SHALL be discarded, with no out_valid for them after release.
REQ-025 The first sample presented on the first edge after rst_n rises SHALL be accepted normally.

Structure
REQ-026 Shared package popcount_pkg SHALL hold the IN_W and ACC_W defaults and the CW width function.
REQ-027 The count logic SHALL be a separate combinational sub-module popcount_comb (IN_W in, CW out), instantiated once in stage 2.

Verification
REQ-028 IN_W=3: drive in=000..111 back-to-back with in_valid=1 -> out = 0,1,1,2,1,2,2,3, each 2 cycles after its input, and acc=12 after the last one.
REQ-029 IN_W=8, ACC_W=4: drive 0xFF, 0xFF -> acc=8 then acc=15 with sat=1; a further 0x01 -> acc=15, sat=1.
REQ-030 Drive in_valid pattern 1,0,1 with data 0x0F,0xFF,0x03 -> out_valid 1,0,1; out 4,(held 4),2; acc 4,4,6.
REQ-031 Assert clr on the same edge that a count of 5 emerges while acc=100 -> acc=5, sat=0; assert clr with no emission -> acc=0.
REQ-032 Assert rst_n=0 between edges with two samples in flight -> all outputs read 0 immediately; after release, out_valid stays 0 until a new sample is driven.
